sysid_boot_checker: RTL

Avalon-MM master-side consumer of the system-ID slave. After reset it reads the slave's two words, word 0 (system ID) and word 1 (build timestamp), and compares them against expected constants. It publishes pass/fail status and the captured values to the NIOS boot logic and the board status LEDs, retrying a bounded number of times before declaring failure.

---
 rtl/sysid_boot_checker.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker
//
// Reads the two words of the system-ID slave after reset (word 0 = system ID,
// word 1 = build timestamp) and compares them with the expected constants.
// A failed compare is retried up to MAX_RETRIES extra times before the result
// is published. A start pulse in DONE reruns the check. mismatch_count
// accumulates failed compares until the next reset.
//
// Optional build macro: SYSID_CHECK_STABLE_EN
//   When defined, each word is sampled twice, back to back, with the address
//   held. A word whose two samples differ is treated as a mismatch. The second
//   sample is the one stored.

module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h5547_181E,
    parameter int          READ_LATENCY = 1,   // 0..3
    parameter int          MAX_RETRIES  = 2    // 0..7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [7:0]  mismatch_count
);

`ifdef SYSID_CHECK_STABLE_EN
    localparam int SAMPLES = 2;
    // Count at which the first of the two samples is taken.
    localparam logic [2:0] FIRST_CNT = 3'(READ_LATENCY);
`else
    localparam int SAMPLES = 1;
`endif

    // Last count of a read state; the stored sample is taken here.
    localparam logic [2:0] LAST_CNT    = 3'(SAMPLES * (READ_LATENCY + 1) - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_reg,      state_next;
    logic [2:0]  cnt_reg,        cnt_next;
    logic [2:0]  attempt_reg,    attempt_next;
    logic        auto_start_reg, auto_start_next;
    logic [31:0] id_value_reg,   id_value_next;
    logic [31:0] ts_value_reg,   ts_value_next;
    logic        id_ok_reg,      id_ok_next;
    logic        ts_ok_reg,      ts_ok_next;
    logic [7:0]  mismatch_reg,   mismatch_next;

`ifdef SYSID_CHECK_STABLE_EN
    logic [31:0] sample_reg,      sample_next;
    logic        id_unstable_reg, id_unstable_next;
    logic        ts_unstable_reg, ts_unstable_next;
`endif

    // Compare results for the word pair captured in the current attempt.
    logic id_match;
    logic ts_match;

`ifdef SYSID_CHECK_STABLE_EN
    assign id_match = (id_value_reg == EXPECTED_ID) && !id_unstable_reg;
    assign ts_match = (ts_value_reg == EXPECTED_TS) && !ts_unstable_reg;
`else
    assign id_match = (id_value_reg == EXPECTED_ID);
    assign ts_match = (ts_value_reg == EXPECTED_TS);
`endif

    // State and datapath registers; reset returns every output to zero and
    // arms the automatic first check.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            attempt_reg     <= '0;
            auto_start_reg  <= 1'b1;
            id_value_reg    <= '0;
            ts_value_reg    <= '0;
            id_ok_reg       <= 1'b0;
            ts_ok_reg       <= 1'b0;
            mismatch_reg    <= '0;
`ifdef SYSID_CHECK_STABLE_EN
            sample_reg      <= '0;
            id_unstable_reg <= 1'b0;
            ts_unstable_reg <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            attempt_reg     <= attempt_next;
            auto_start_reg  <= auto_start_next;
            id_value_reg    <= id_value_next;
            ts_value_reg    <= ts_value_next;
            id_ok_reg       <= id_ok_next;
            ts_ok_reg       <= ts_ok_next;
            mismatch_reg    <= mismatch_next;
`ifdef SYSID_CHECK_STABLE_EN
            sample_reg      <= sample_next;
            id_unstable_reg <= id_unstable_next;
            ts_unstable_reg <= ts_unstable_next;
`endif
        end
    end

    // Next-state and datapath update: read word 0, read word 1, compare,
    // then either retry or publish the result.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        attempt_next     = attempt_reg;
        auto_start_next  = auto_start_reg;
        id_value_next    = id_value_reg;
        ts_value_next    = ts_value_reg;
        id_ok_next       = id_ok_reg;
        ts_ok_next       = ts_ok_reg;
        mismatch_next    = mismatch_reg;
`ifdef SYSID_CHECK_STABLE_EN
        sample_next      = sample_reg;
        id_unstable_next = id_unstable_reg;
        ts_unstable_next = ts_unstable_reg;
`endif

        case (state_reg)
            IDLE: begin
                // Only reached through reset; the armed flag launches the
                // first check on the first edge after reset release.
                if (auto_start_reg) begin
                    auto_start_next = 1'b0;
                    cnt_next        = '0;
                    state_next      = RD_ID;
                end
            end

            RD_ID: begin
                cnt_next = cnt_reg + 3'd1;
`ifdef SYSID_CHECK_STABLE_EN
                if (cnt_reg == FIRST_CNT) begin
                    sample_next = sysid_readdata;
                end
`endif
                if (cnt_reg == LAST_CNT) begin
                    cnt_next      = '0;
                    id_value_next = sysid_readdata;
`ifdef SYSID_CHECK_STABLE_EN
                    id_unstable_next = (sysid_readdata != sample_reg);
`endif
                    state_next    = RD_TS;
                end
            end

            RD_TS: begin
                cnt_next = cnt_reg + 3'd1;
`ifdef SYSID_CHECK_STABLE_EN
                if (cnt_reg == FIRST_CNT) begin
                    sample_next = sysid_readdata;
                end
`endif
                if (cnt_reg == LAST_CNT) begin
                    cnt_next      = '0;
                    ts_value_next = sysid_readdata;
`ifdef SYSID_CHECK_STABLE_EN
                    ts_unstable_next = (sysid_readdata != sample_reg);
`endif
                    state_next    = CMP;
                end
            end

            CMP: begin
                id_ok_next = id_match;
                ts_ok_next = ts_match;
                if (id_match && ts_match) begin
                    state_next = DONE;
                end else begin
                    // Saturate so a long-running board never wraps to zero.
                    if (mismatch_reg != 8'hFF) begin
                        mismatch_next = mismatch_reg + 8'd1;
                    end
                    if (attempt_reg < RETRY_LIMIT) begin
                        attempt_next = attempt_reg + 3'd1;
                        cnt_next     = '0;
                        state_next   = RD_ID;
                    end else begin
                        state_next   = DONE;
                    end
                end
            end

            DONE: begin
                // Re-check request; the failure history is kept.
                if (start) begin
                    id_ok_next   = 1'b0;
                    ts_ok_next   = 1'b0;
                    attempt_next = '0;
                    cnt_next     = '0;
                    state_next   = RD_ID;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state.
    assign sysid_address  = (state_reg == RD_TS);
    assign busy           = (state_reg == RD_ID) || (state_reg == RD_TS) || (state_reg == CMP);
    assign done           = (state_reg == DONE);
    assign pass           = done && id_ok_reg && ts_ok_reg;
    assign id_ok          = id_ok_reg;
    assign ts_ok          = ts_ok_reg;
    assign id_value       = id_value_reg;
    assign ts_value       = ts_value_reg;
    assign mismatch_count = mismatch_reg;

endmodule
